pht_update_sched: RTL
=====================

PHT_UPDATE_SCHED -- requirements
Module: pht_update_sched

Interface
- REQ-001 SHALL have parameter PHT_IDX_W, default 6: pattern-history-table (PHT) index width; the table holds 2^PHT_IDX_W 2-bit counters.
- REQ-002 SHALL have parameter UPD_DEPTH, default 4: number of update-queue entries; power of two, at least 2.
- REQ-003 SHALL have parameter STARVE_LIMIT, default 8: number of consecutive lost-arbitration cycles before an update is forced.
- REQ-004 clk_i  input  1  single clock; every register is updated on its rising edge.
- REQ-005 rst_ni  input  1  synchronous, active-high reset; the name is kept for codebase consistency.
- REQ-006 lkp_valid_i  input  1  fetch requests a counter lookup.
- REQ-007 lkp_idx_i  input  PHT_IDX_W  lookup index.
- REQ-008 lkp_ready_o  output  1  the lookup is accepted this cycle.
- REQ-009 lkp_rvalid_o  output  1  lookup result is valid; asserted exactly 1 cycle after acceptance.
- REQ-010 lkp_taken_o  output  1  prediction; equals the counter MSB; qualified by lkp_rvalid_o.
- REQ-011 upd_valid_i  input  1  execute stage presents a resolved branch.
- REQ-012 upd_idx_i  input  PHT_IDX_W  index to train.
- REQ-013 upd_taken_i  input  1  actual branch outcome.
- REQ-014 upd_ready_o  output  1  the update queue is not full.
- REQ-015 pht_en_o  output  1  PHT port access strobe.
- REQ-016 pht_we_o  output  1  1 = write, 0 = read.
- REQ-017 pht_addr_o  output  PHT_IDX_W  PHT port address.
- REQ-018 pht_wdata_o  output  2  counter write data.
- REQ-019 pht_rdata_i  input  2  read data; valid 1 cycle after a read strobe.
- REQ-020 busy_o  output  1  queue is non-empty, an update is in flight, or initialization is running.

Function
- REQ-021 Counter encoding SHALL be: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken; the prediction is the MSB.
- REQ-022 An update SHALL saturate: on taken, +1 capped at 11; on not-taken, -1 floored at 00.
- REQ-023 The update queue SHALL be a FIFO; it pushes when upd_valid_i && upd_ready_o.
- REQ-024 upd_ready_o SHALL equal !full and SHALL NOT depend on a same-cycle pop; a simultaneous push and pop SHALL keep the count unchanged.
- REQ-025 The scheduler SHALL have states INIT, IDLE and UPD_WR.
- REQ-026 The PHT port SHALL perform at most one access per cycle.
- REQ-027 IDLE, queue empty: lkp_ready_o = 1; an accepted lookup drives a read of lkp_idx_i.
- REQ-028 IDLE, queue non-empty, not forced: lookup priority applies; with lkp_valid_i = 1 the lookup is served; with lkp_valid_i = 0 the scheduler issues a read of the head index and goes to UPD_WR.
- REQ-029 An update is forced when the queue is full or the starvation counter equals STARVE_LIMIT.
- REQ-030 On a forced update: lkp_ready_o = 0, the head-index read is issued, and the FSM goes to UPD_WR.
- REQ-031 UPD_WR SHALL last exactly 1 cycle: write the saturated counter (computed from pht_rdata_i) to the head index, pop the head, return to IDLE.
- REQ-032 In UPD_WR, lkp_ready_o SHALL be 0.
- REQ-033 The starvation counter SHALL increment each IDLE cycle in which the queue is non-empty and a lookup wins.
- REQ-034 The starvation counter SHALL clear when an update read issues, and SHALL saturate at STARVE_LIMIT.
- REQ-035 Updates to the same index SHALL be applied sequentially in queue order, with no lost increments.
- REQ-036 A lookup accepted after an update's write cycle SHALL observe the written value.
- REQ-037 Lookup latency SHALL be 1 cycle; update occupancy SHALL be 2 port cycles (read, then write).

Reset
- REQ-038 On rst_ni = 1: queue emptied, starvation counter = 0, any in-flight update abandoned (no write issued).
- REQ-039 On rst_ni = 1: lkp_rvalid_o, pht_en_o, pht_we_o and upd_ready_o = 0; pht_addr_o and pht_wdata_o = 0.
- REQ-040 On rst_ni = 1: the FSM enters INIT if TCORE_PHT_INIT_EN is defined, otherwise IDLE.
- REQ-041 busy_o after reset SHALL be 1 with TCORE_PHT_INIT_EN and 0 without it.

Configuration
- REQ-042 With macro TCORE_PHT_INIT_EN defined, INIT SHALL write 01 to indices 0 .. 2^PHT_IDX_W-1, one per cycle, then enter IDLE.
- REQ-043 During INIT: lkp_ready_o = 0, upd_ready_o = 1 when not full (updates are queued), busy_o = 1.
- REQ-044 Without TCORE_PHT_INIT_EN, the INIT state and its sweep counter SHALL NOT be synthesized, and PHT contents are owned externally.

Verification
- REQ-045 Init (TCORE_PHT_INIT_EN, PHT_IDX_W = 6) -> 64 consecutive writes of 01 to addresses 0..63, lkp_ready_o = 0 throughout, then a lookup of idx 5 gives lkp_taken_o = 0.
- REQ-046 Saturation: 4 taken updates to idx 3 from 01, then lookup -> writes 10, 11, 11, 11; lkp_taken_o = 1; 3 not-taken updates -> final counter 00.
- REQ-047 Starvation: lkp_valid_i held at 1 with one queued update -> 8 lookups accepted, 9th cycle lkp_ready_o = 0 and a read of the head index, next cycle a write, then lookups resume.
- REQ-048 Full queue: 4 updates pushed while lookups continuous -> upd_ready_o = 0 on the 4th-entry-occupied cycle, the update is forced immediately, upd_ready_o = 1 the cycle after the pop.
- REQ-049 Reset in UPD_WR: rst_ni asserted in the write cycle -> no write issued, queue empty, busy_o per REQ-041, and counter values from before the reset are unchanged.
- REQ-050 Simultaneous push and pop at count 3 -> count stays 3, order preserved, and two same-index updates yield +2 net.

Source files
------------

// File: rtl/pht_update_sched.sv
// PHT update scheduler: shares one pattern-history-table port between fetch lookups and a FIFO of resolved-branch counter updates.
// Define TCORE_PHT_INIT_EN to add a power-up sweep that writes weak-not-taken (01) to every counter.
module pht_update_sched #(
    parameter int PHT_IDX_W    = 6,
    parameter int UPD_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lkp_valid_i,
    input  logic [PHT_IDX_W-1:0] lkp_idx_i,
    output logic                 lkp_ready_o,
    output logic                 lkp_rvalid_o,
    output logic                 lkp_taken_o,
    input  logic                 upd_valid_i,
    input  logic [PHT_IDX_W-1:0] upd_idx_i,
    input  logic                 upd_taken_i,
    output logic                 upd_ready_o,
    output logic                 pht_en_o,
    output logic                 pht_we_o,
    output logic [PHT_IDX_W-1:0] pht_addr_o,
    output logic [1:0]           pht_wdata_o,
    input  logic [1:0]           pht_rdata_i,
    output logic                 busy_o
);

    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(UPD_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

`ifdef TCORE_PHT_INIT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_UPD_WR, ST_INIT} state_e;
    localparam state_e ST_RESET = ST_INIT;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_UPD_WR} state_e;
    localparam state_e ST_RESET = ST_IDLE;
`endif

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic                 rvalid_q, rvalid_d;
    logic [PHT_IDX_W:0]   fifo_q [UPD_DEPTH];
`ifdef TCORE_PHT_INIT_EN
    logic [PHT_IDX_W-1:0] init_idx_q, init_idx_d;
`endif

    logic                 empty, full, forced;
    logic                 upd_rdy, push;
    logic [PHT_IDX_W-1:0] head_idx;
    logic                 head_taken;
    logic                 lkp_rdy_c, lkp_acc_c, pop_c;
    logic                 en_c, we_c;
    logic [PHT_IDX_W-1:0] addr_c;
    logic [1:0]           wdata_c;

    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == CNT_FULL);
    // A non-empty queue is drained ahead of lookups once full or once lookups have won STARVE_LIMIT times in a row.
    assign forced     = !empty && (full || (starve_q == STV_MAX));
    assign upd_rdy    = !full && !rst_ni;
    assign push       = upd_valid_i && upd_rdy;
    assign head_idx   = fifo_q[rd_ptr_q][PHT_IDX_W:1];
    assign head_taken = fifo_q[rd_ptr_q][0];

    assign cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop_c);
    assign wr_ptr_d = push  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign rvalid_d = lkp_acc_c;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        lkp_rdy_c = 1'b0;
        lkp_acc_c = 1'b0;
        pop_c     = 1'b0;
        en_c      = 1'b0;
        we_c      = 1'b0;
        addr_c    = '0;
        wdata_c   = 2'b00;
`ifdef TCORE_PHT_INIT_EN
        init_idx_d = init_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (forced) begin
                    en_c     = 1'b1;
                    addr_c   = head_idx;
                    starve_d = '0;
                    state_d  = ST_UPD_WR;
                end else begin
                    lkp_rdy_c = 1'b1;
                    if (lkp_valid_i) begin
                        lkp_acc_c = 1'b1;
                        en_c      = 1'b1;
                        addr_c    = lkp_idx_i;
                        if (!empty && (starve_q != STV_MAX)) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end else if (!empty) begin
                        en_c     = 1'b1;
                        addr_c   = head_idx;
                        starve_d = '0;
                        state_d  = ST_UPD_WR;
                    end
                end
            end
            // Read data for the head arrived this cycle; write back the trained counter and retire the entry.
            ST_UPD_WR: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = head_idx;
                wdata_c = sat_update(pht_rdata_i, head_taken);
                pop_c   = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef TCORE_PHT_INIT_EN
            ST_INIT: begin
                en_c       = 1'b1;
                we_c       = 1'b1;
                addr_c     = init_idx_q;
                wdata_c    = 2'b01;
                init_idx_d = init_idx_q + PHT_IDX_W'(1);
                if (init_idx_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            starve_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef TCORE_PHT_INIT_EN
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            init_idx_q <= '0;
        end else begin
            init_idx_q <= init_idx_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {upd_idx_i, upd_taken_i};
        end
    end

    // Port strobes are combinational, so reset must mask them directly to abandon an in-flight write.
    assign lkp_ready_o  = lkp_rdy_c && !rst_ni;
    assign lkp_rvalid_o = rvalid_q;
    assign lkp_taken_o  = rvalid_q && pht_rdata_i[1];
    assign upd_ready_o  = upd_rdy;
    assign pht_en_o     = en_c && !rst_ni;
    assign pht_we_o     = we_c && !rst_ni;
    assign pht_addr_o   = rst_ni ? '0 : addr_c;
    assign pht_wdata_o  = rst_ni ? 2'b00 : wdata_c;
    assign busy_o       = !empty || (state_q != ST_IDLE);

endmodule
